extensor_inmediato: RTL and testbench
=====================================

# extensor_inmediato

Pipelined immediate-generation unit for the ID stage of the MIPS core. It replaces a purely combinational sign extender with a parametrised, registered block that supports six extension modes, flags illegal modes and sits between decode and the ID/EX register. A 2-entry skid buffer provides a valid/ready handshake, so the pipeline can stall without a combinational ready path.

## Interface
Parameters:
- IMM_NBITS, 26, width of instruction immediate field (bits [25:0]); fixed minimum 26
- HALF_NBITS, 16, width of I-type immediate
- DATA_NBITS, 32, output width; must be ≥ 32

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_valid  in  1  upstream entry valid
- o_ready  out  1  block can accept an entry this cycle
- i_id_inmediate  in  IMM_NBITS  instruction bits [25:0]
- i_extension_mode  in  3  extension mode
- i_pc_plus4  in  DATA_NBITS  PC+4 of the instruction
- i_flush  in  1  synchronous pipeline flush
- o_valid  out  1  output entry valid
- i_ready  in  1  downstream accepts output
- o_extensionresult  out  DATA_NBITS  extended value
- o_illegal  out  1  entry carried an illegal mode

## Operation
- Modes, with imm = i_id_inmediate[HALF_NBITS-1:0]:
  - 000: sign-extend imm to DATA_NBITS
  - 001: zero-extend imm
  - 010: LUI: imm in bits [31:16], zeros below; sign-extend bit 31 above bit 31 if DATA_NBITS > 32
  - 011: branch offset: sign-extended imm shifted left 2, truncated to DATA_NBITS
  - 100: jump target: {i_pc_plus4[DATA_NBITS-1:28], i_id_inmediate[25:0], 2'b00}
  - 101: shift amount: zero-extend i_id_inmediate[10:6]
  - 110, 111: illegal: result all ones, o_illegal=1
- Storage: output register (OUT) and skid register (SKID), each with a valid bit.
- States: EMPTY (neither valid), ONE (OUT valid), FULL (OUT and SKID valid).
- o_ready = !SKID.valid, driven directly from the register.
- Accept when i_valid && o_ready. Output transfer when o_valid && i_ready.
- EMPTY: accept → ONE, result loaded into OUT.
- ONE:
  - accept with transfer → ONE, OUT reloaded
  - accept without transfer → FULL, new entry into SKID
  - transfer only → EMPTY
- FULL: no accept. Transfer → ONE, SKID moves to OUT.
- Ordering is strictly FIFO. No entry is dropped or duplicated except on flush.
- i_flush (priority over everything): next cycle EMPTY. Any accept or transfer in the same cycle is discarded. o_ready reads 1 the cycle after flush.
- The mode decode is combinational before the register. i_pc_plus4 is sampled only at accept.

## Timing
- Reset (async assert, sync release): o_valid=0, o_extensionresult=0, o_illegal=0, SKID.valid=0, so o_ready=1.
- Reset mid-operation: all entries are discarded immediately.
- Latency: entry accepted at edge N appears on o_valid/o_extensionresult after edge N, i.e. 1 cycle.
- Throughput: 1 entry per cycle while i_ready=1.
- With i_ready held low, o_ready falls one cycle after the second accept. At most 2 entries are buffered.
- Outputs hold stable while o_valid=1 && i_ready=0.

## Configuration
- EXTENSOR_BRANCH_TARGET_EN:
  - Defined: mode 011 outputs i_pc_plus4 + (sext(imm) << 2), modulo 2^DATA_NBITS, i.e. the full branch target. This adds a DATA_NBITS adder before OUT.
  - Undefined: mode 011 outputs the shifted offset only, and i_pc_plus4 is ignored for mode 011.
- Latency is 1 cycle in both builds.

## Test plan
- Reset then mode 000, imm 16'h8000, i_ready=1 → one cycle later o_valid=1, result 32'hFFFF8000, o_illegal=0.
- Modes 001/010/101 with i_id_inmediate=26'h00087C0 (imm=16'h87C0) → 32'h000087C0 / 32'h87C00000 / 32'h0000001F.
- Mode 100, i_pc_plus4=32'hA0000004, i_id_inmediate=26'h3FFFFFF → 32'hAFFFFFFC.
- Mode 011, imm 16'hFFFF, i_pc_plus4=32'h00001000:
  - macro undefined → 32'hFFFFFFFC
  - macro defined → 32'h00000FFC
- Mode 110 → result 32'hFFFFFFFF, o_illegal=1. Subsequent legal entry → o_illegal=0.
- Backpressure:
  - i_ready=0, three back-to-back entries A, B, C → o_ready=0 after B, C held upstream.
  - Release i_ready → outputs A, B, C in order, no loss.
  - i_flush while FULL → o_valid=0 next cycle, o_ready=1.

Source files
------------

// File: rtl/extensor_inmediato.sv
// Immediate generator for the ID stage: six extension modes, illegal-mode flag, 2-entry skid buffer.
// Latency: 1 cycle from accept to o_valid; 1 entry/cycle throughput while i_ready=1.
// Backpressure: o_ready comes straight from the skid-valid flop; at most 2 entries held, FIFO order.
// Optional build macro EXTENSOR_BRANCH_TARGET_EN: mode 011 yields PC+4 + offset instead of the bare offset.
module extensor_inmediato #(
    parameter int IMM_NBITS  = 26,
    parameter int HALF_NBITS = 16,
    parameter int DATA_NBITS = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [IMM_NBITS-1:0]  i_id_inmediate,
    input  logic [2:0]            i_extension_mode,
    input  logic [DATA_NBITS-1:0] i_pc_plus4,
    input  logic                  i_flush,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_NBITS-1:0] o_extensionresult,
    output logic                  o_illegal
);

    localparam logic [2:0] MODE_SEXT   = 3'b000;
    localparam logic [2:0] MODE_ZEXT   = 3'b001;
    localparam logic [2:0] MODE_LUI    = 3'b010;
    localparam logic [2:0] MODE_BRANCH = 3'b011;
    localparam logic [2:0] MODE_JUMP   = 3'b100;
    localparam logic [2:0] MODE_SHAMT  = 3'b101;

    // Bit 0 = OUT holds an entry, bit 1 = SKID holds an entry.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b11
    } state_e;

    state_e                  state_q, state_d;
    logic [DATA_NBITS-1:0]   out_dat_q, out_dat_d;
    logic                    out_ill_q, out_ill_d;
    logic [DATA_NBITS-1:0]   skid_dat_q, skid_dat_d;
    logic                    skid_ill_q, skid_ill_d;

    logic [HALF_NBITS-1:0]   imm_half;
    logic [DATA_NBITS-1:0]   sext_imm;
    logic [DATA_NBITS-1:0]   branch_off;
    logic [DATA_NBITS-1:0]   lui_val;
    logic [DATA_NBITS-1:0]   jump_val;
    logic [DATA_NBITS-1:0]   shamt_val;
    logic [DATA_NBITS-1:0]   branch_val;
    logic [DATA_NBITS-1:0]   dec_res;
    logic                    dec_ill;
    logic                    accept;
    logic                    xfer;

    assign imm_half   = i_id_inmediate[HALF_NBITS-1:0];
    assign sext_imm   = {{(DATA_NBITS-HALF_NBITS){imm_half[HALF_NBITS-1]}}, imm_half};
    assign branch_off = sext_imm << 2;
    // Shifting the sign-extended value puts imm at [31:16] and replicates bit 31 above it.
    assign lui_val    = sext_imm << (32 - HALF_NBITS);
    assign jump_val   = {i_pc_plus4[DATA_NBITS-1:28], i_id_inmediate[25:0], 2'b00};
    assign shamt_val  = {{(DATA_NBITS-5){1'b0}}, i_id_inmediate[10:6]};

`ifdef EXTENSOR_BRANCH_TARGET_EN
    assign branch_val = i_pc_plus4 + branch_off;
`else
    assign branch_val = branch_off;
    // Only the upper PC bits feed the jump target when the branch adder is absent.
    logic unused_pc_low;
    assign unused_pc_low = ^i_pc_plus4[27:0];
`endif

    // Mode decode ahead of the output register; illegal modes saturate to all ones.
    always_comb begin
        dec_res = '1;
        dec_ill = 1'b0;
        case (i_extension_mode)
            MODE_SEXT:   dec_res = sext_imm;
            MODE_ZEXT:   dec_res = {{(DATA_NBITS-HALF_NBITS){1'b0}}, imm_half};
            MODE_LUI:    dec_res = lui_val;
            MODE_BRANCH: dec_res = branch_val;
            MODE_JUMP:   dec_res = jump_val;
            MODE_SHAMT:  dec_res = shamt_val;
            default: begin
                dec_res = '1;
                dec_ill = 1'b1;
            end
        endcase
    end

    // Handshake signals come straight from the state flops, no combinational ready path.
    assign o_valid           = state_q[0];
    assign o_ready           = ~state_q[1];
    assign o_extensionresult = out_dat_q;
    assign o_illegal         = out_ill_q;

    assign accept = i_valid & o_ready;
    assign xfer   = o_valid & i_ready;

    // Skid-buffer next state: flush wins, otherwise load OUT/SKID according to accept and transfer.
    always_comb begin
        state_d    = state_q;
        out_dat_d  = out_dat_q;
        out_ill_d  = out_ill_q;
        skid_dat_d = skid_dat_q;
        skid_ill_d = skid_ill_q;
        if (i_flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d   = ST_ONE;
                        out_dat_d = dec_res;
                        out_ill_d = dec_ill;
                    end
                end
                ST_ONE: begin
                    if (accept && xfer) begin
                        out_dat_d = dec_res;
                        out_ill_d = dec_ill;
                    end else if (accept) begin
                        state_d    = ST_FULL;
                        skid_dat_d = dec_res;
                        skid_ill_d = dec_ill;
                    end else if (xfer) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (xfer) begin
                        state_d   = ST_ONE;
                        out_dat_d = skid_dat_q;
                        out_ill_d = skid_ill_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // State and data registers; reset discards every buffered entry at once.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_EMPTY;
            out_dat_q  <= '0;
            out_ill_q  <= 1'b0;
            skid_dat_q <= '0;
            skid_ill_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            out_dat_q  <= out_dat_d;
            out_ill_q  <= out_ill_d;
            skid_dat_q <= skid_dat_d;
            skid_ill_q <= skid_ill_d;
        end
    end

endmodule

// File: tb/tb_extensor_inmediato.sv
// Bench for extensor_inmediato: queue-based reference model checked every cycle, plus literal checks.
// Latency: stimulus driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Backpressure: random i_ready/i_flush, a mid-run reset and directed fill/drain/flush sequences.
module tb_extensor_inmediato;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [25:0] i_id_inmediate = '0;
    logic [2:0]  i_extension_mode = '0;
    logic [31:0] i_pc_plus4 = '0;
    logic        i_flush = 1'b0;
    logic        o_valid;
    logic        i_ready = 1'b1;
    logic [31:0] o_extensionresult;
    logic        o_illegal;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] res;
        logic        ill;
    } ent_t;

    ent_t q[$];

`ifdef EXTENSOR_BRANCH_TARGET_EN
    localparam logic [31:0] BRANCH_EXP = 32'h0000_0FFC;
`else
    localparam logic [31:0] BRANCH_EXP = 32'hFFFF_FFFC;
`endif

    extensor_inmediato dut (
        .i_clk             (i_clk),
        .i_rst_n           (i_rst_n),
        .i_valid           (i_valid),
        .o_ready           (o_ready),
        .i_id_inmediate    (i_id_inmediate),
        .i_extension_mode  (i_extension_mode),
        .i_pc_plus4        (i_pc_plus4),
        .i_flush           (i_flush),
        .o_valid           (o_valid),
        .i_ready           (i_ready),
        .o_extensionresult (o_extensionresult),
        .o_illegal         (o_illegal)
    );

    always #5 i_clk = ~i_clk;

    // Expected result from the mode rules, using plain integer arithmetic.
    function automatic ent_t model(input logic [2:0] m, input logic [25:0] imm, input logic [31:0] pc);
        ent_t        e;
        logic [15:0] h;
        int signed   sv;
        h     = imm[15:0];
        sv    = int'($signed(h));
        e.ill = 1'b0;
        case (m)
            3'd0: e.res = 32'(sv);
            3'd1: e.res = {16'h0000, h};
            3'd2: e.res = 32'(h) * 32'h0001_0000;
`ifdef EXTENSOR_BRANCH_TARGET_EN
            3'd3: e.res = 32'(sv * 4) + pc;
`else
            3'd3: e.res = 32'(sv * 4);
`endif
            3'd4: e.res = (pc & 32'hF000_0000) | (32'(imm) * 32'd4);
            3'd5: e.res = (32'(imm) / 32'd64) % 32'd32;
            default: begin
                e.res = 32'hFFFF_FFFF;
                e.ill = 1'b1;
            end
        endcase
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, required %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a FIFO of at most two entries, emptied by flush or reset.
    always @(posedge i_clk or negedge i_rst_n) begin : mdl
        bit acc;
        bit xf;
        if (!i_rst_n) begin
            q.delete();
        end else begin
            acc = i_valid && (q.size() < 2);
            xf  = i_ready && (q.size() > 0);
            if (i_flush) begin
                q.delete();
            end else begin
                if (xf) void'(q.pop_front());
                if (acc) q.push_back(model(i_extension_mode, i_id_inmediate, i_pc_plus4));
            end
        end
    end

    // Every-cycle comparison of the DUT against the model.
    always @(negedge i_clk) begin
        check("o_valid", 32'(o_valid), 32'(q.size() > 0));
        check("o_ready", 32'(o_ready), 32'(q.size() < 2));
        if (q.size() > 0) begin
            check("result", o_extensionresult, q[0].res);
            check("illegal", 32'(o_illegal), 32'(q[0].ill));
        end
        if (!i_rst_n) check("reset_result", o_extensionresult, 32'h0);
    end

    task automatic send(input logic [2:0] m, input logic [25:0] imm, input logic [31:0] pc);
        bit acc;
        acc = 1'b0;
        i_valid          = 1'b1;
        i_extension_mode = m;
        i_id_inmediate   = imm;
        i_pc_plus4       = pc;
        for (int k = 0; k < 20 && !acc; k++) begin
            @(negedge i_clk);
            acc = o_ready;
            @(posedge i_clk);
            #1;
        end
        i_valid = 1'b0;
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL send_timeout: o_ready stayed 0, required 1");
        end
    endtask

    task automatic send_chk(input string name, input logic [2:0] m, input logic [25:0] imm,
                            input logic [31:0] pc, input logic [31:0] exp, input logic ill);
        send(m, imm, pc);
        @(negedge i_clk);
        check({name, "_vld"}, 32'(o_valid), 32'd1);
        check(name, o_extensionresult, exp);
        check({name, "_ill"}, 32'(o_illegal), 32'(ill));
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        i_rst_n = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_ready", 32'(o_ready), 32'd1);
        check("rst_result", o_extensionresult, 32'h0);
        check("rst_illegal", 32'(o_illegal), 32'd0);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;

        // Directed mode checks with hand-computed results.
        i_ready = 1'b1;
        send_chk("sext",   3'b000, 26'h0008000, 32'h0, 32'hFFFF_8000, 1'b0);
        send_chk("zext",   3'b001, 26'h00087C0, 32'h0, 32'h0000_87C0, 1'b0);
        send_chk("lui",    3'b010, 26'h00087C0, 32'h0, 32'h87C0_0000, 1'b0);
        send_chk("shamt",  3'b101, 26'h00087C0, 32'h0, 32'h0000_001F, 1'b0);
        send_chk("jump",   3'b100, 26'h3FFFFFF, 32'hA000_0004, 32'hAFFF_FFFC, 1'b0);
        send_chk("branch", 3'b011, 26'h000FFFF, 32'h0000_1000, BRANCH_EXP, 1'b0);
        send_chk("illeg6", 3'b110, 26'h0001234, 32'h0, 32'hFFFF_FFFF, 1'b1);
        send_chk("legal",  3'b000, 26'h0000001, 32'h0, 32'h0000_0001, 1'b0);
        send_chk("illeg7", 3'b111, 26'h0000000, 32'h0, 32'hFFFF_FFFF, 1'b1);

        // Fill with i_ready low: A and B buffered, C held upstream.
        i_ready = 1'b0;
        i_valid = 1'b1; i_extension_mode = 3'b001; i_id_inmediate = 26'h0000111;
        @(posedge i_clk); #1;
        i_id_inmediate = 26'h0000222;
        @(posedge i_clk); #1;
        i_id_inmediate = 26'h0000333;
        @(negedge i_clk);
        check("bp_ready_low", 32'(o_ready), 32'd0);
        check("bp_hold_a", o_extensionresult, 32'h0000_0111);
        @(posedge i_clk); #1;
        @(negedge i_clk);
        check("bp_still_low", 32'(o_ready), 32'd0);
        check("bp_still_a", o_extensionresult, 32'h0000_0111);
        @(posedge i_clk); #1;
        i_ready = 1'b1;
        @(negedge i_clk);
        check("bp_out_a", o_extensionresult, 32'h0000_0111);
        @(posedge i_clk); #1;
        @(negedge i_clk);
        check("bp_out_b", o_extensionresult, 32'h0000_0222);
        check("bp_ready_back", 32'(o_ready), 32'd1);
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        @(negedge i_clk);
        check("bp_out_c", o_extensionresult, 32'h0000_0333);
        check("bp_c_vld", 32'(o_valid), 32'd1);
        @(posedge i_clk); #1;
        @(negedge i_clk);
        check("bp_drained", 32'(o_valid), 32'd0);

        // Flush while full.
        @(posedge i_clk); #1;
        i_ready = 1'b0;
        i_valid = 1'b1; i_extension_mode = 3'b000; i_id_inmediate = 26'h0000005;
        @(posedge i_clk); #1;
        i_id_inmediate = 26'h0000006;
        @(posedge i_clk); #1;
        i_id_inmediate = 26'h0000007;
        @(negedge i_clk);
        check("fl_full", 32'(o_ready), 32'd0);
        i_flush = 1'b1;
        i_ready = 1'b1;
        @(posedge i_clk); #1;
        i_flush = 1'b0;
        i_valid = 1'b0;
        @(negedge i_clk);
        check("fl_vld", 32'(o_valid), 32'd0);
        check("fl_rdy", 32'(o_ready), 32'd1);
        @(posedge i_clk); #1;

        // Randomized traffic with occasional flush and one asynchronous reset pulse.
        for (int c = 0; c < 3000; c++) begin
            i_valid          = ($urandom_range(0, 3) != 0);
            i_ready          = ($urandom_range(0, 9) < 6);
            i_extension_mode = 3'($urandom_range(0, 7));
            i_id_inmediate   = 26'($urandom);
            i_pc_plus4       = $urandom;
            i_flush          = ($urandom_range(0, 31) == 0);
            if (c == 1500) i_rst_n = 1'b0;
            if (c == 1503) i_rst_n = 1'b1;
            @(posedge i_clk);
            #1;
        end
        i_valid = 1'b0;
        i_flush = 1'b0;
        i_ready = 1'b1;
        repeat (4) @(posedge i_clk);
        #1;
        check("final_empty", 32'(o_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
